// File: rtl/exu_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the NPC execute path.
// Define EXU_SEQ_CTRL_PERF_EN to add the cycle_cnt_o / instret_cnt_o counters.
module exu_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             ifu_req_o,
  input  logic             ifu_req_ready_i,
  input  logic             ifu_rvalid_i,
  output logic             inst_valid_o,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic             ebreak_i,
  input  logic             exu_rf_wen_i,
  output logic             lsu_req_o,
  input  logic             lsu_ready_i,
  input  logic             lsu_done_i,
  output logic             rf_wen_o,
  output logic             pc_wen_o,
  output logic             trap_o,
  output logic             halted_o,
  output logic             err_o
`ifdef EXU_SEQ_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
`endif
);

  if (TIMEOUT == 0 || TIMEOUT > 255 || CNT_W == 0) begin : g_param_check
    $error("exu_seq_ctrl: TIMEOUT must be 1..255 and CNT_W non-zero");
  end

  typedef enum logic [2:0] {
    StFetch,
    StFWait,
    StExec,
    StMem,
    StMWait,
    StWb,
    StHalt,
    StErr
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic       wd_expire;

  // Expiry fires on the wait cycle that brings the count up to TIMEOUT.
  assign wd_expire = (wd_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    unique case (state_q)
      StFetch: begin
        wd_d = '0;
        if (ifu_req_ready_i) state_d = StFWait;
      end
      StFWait: begin
        wd_d = wd_q + 8'd1;
        if (ifu_rvalid_i) begin
          state_d = StExec;
          wd_d    = '0;
        end else if (wd_expire) begin
          state_d = StErr;
        end
      end
      StExec: begin
        if (ebreak_i)                    state_d = StHalt;
        else if (is_load_i || is_store_i) state_d = StMem;
        else                              state_d = StWb;
      end
      StMem: begin
        wd_d = '0;
        if (lsu_ready_i) state_d = StMWait;
      end
      StMWait: begin
        wd_d = wd_q + 8'd1;
        if (lsu_done_i) begin
          state_d = StWb;
          wd_d    = '0;
        end else if (wd_expire) begin
          state_d = StErr;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      StErr:   state_d = StErr;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Everything is forced low while reset is held, whatever state is being left.
  always_comb begin
    ifu_req_o    = 1'b0;
    inst_valid_o = 1'b0;
    lsu_req_o    = 1'b0;
    rf_wen_o     = 1'b0;
    pc_wen_o     = 1'b0;
    trap_o       = 1'b0;
    halted_o     = 1'b0;
    err_o        = 1'b0;
    if (!rst_i) begin
      ifu_req_o    = (state_q == StFetch);
      inst_valid_o = (state_q == StExec);
      lsu_req_o    = (state_q == StMem);
      pc_wen_o     = (state_q == StWb);
      rf_wen_o     = (state_q == StWb) && exu_rf_wen_i && !is_store_i;
      trap_o       = (state_q == StExec) && ebreak_i;
      halted_o     = (state_q == StHalt);
      err_o        = (state_q == StErr);
    end
  end

`ifdef EXU_SEQ_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != StHalt && state_q != StErr) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (state_q == StWb) instret_cnt_q <= instret_cnt_q + 1'b1;
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Directed cycle-by-cycle vector bench for exu_seq_ctrl (TIMEOUT = 4).
module tb_exu_seq_ctrl;

  localparam int unsigned Timeout = 4;
  localparam int unsigned CntW    = 32;

  // Input bits: {rst, ifu_req_ready, ifu_rvalid, is_load, is_store, ebreak, exu_rf_wen,
  //              lsu_ready, lsu_done}
  localparam logic [8:0] R   = 9'b1_0000_0000;
  localparam logic [8:0] RDY = 9'b0_1000_0000;
  localparam logic [8:0] RV  = 9'b0_0100_0000;
  localparam logic [8:0] LD  = 9'b0_0010_0000;
  localparam logic [8:0] ST  = 9'b0_0001_0000;
  localparam logic [8:0] EB  = 9'b0_0000_1000;
  localparam logic [8:0] WEN = 9'b0_0000_0100;
  localparam logic [8:0] LR  = 9'b0_0000_0010;
  localparam logic [8:0] DN  = 9'b0_0000_0001;

  // Output bits: {ifu_req, inst_valid, lsu_req, rf_wen, pc_wen, trap, halted, err}
  localparam logic [7:0] O_REQ  = 8'b1000_0000;
  localparam logic [7:0] O_IV   = 8'b0100_0000;
  localparam logic [7:0] O_LSU  = 8'b0010_0000;
  localparam logic [7:0] O_RF   = 8'b0001_0000;
  localparam logic [7:0] O_PC   = 8'b0000_1000;
  localparam logic [7:0] O_TRAP = 8'b0000_0100;
  localparam logic [7:0] O_HALT = 8'b0000_0010;
  localparam logic [7:0] O_ERR  = 8'b0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ifu_req, ifu_req_ready, ifu_rvalid, inst_valid, is_load, is_store, ebreak;
  logic exu_rf_wen, lsu_req, lsu_ready, lsu_done, rf_wen, pc_wen, trap, halted, err;
`ifdef EXU_SEQ_CTRL_PERF_EN
  logic [CntW-1:0] cycle_cnt, instret_cnt;
`endif

  exu_seq_ctrl #(
    .TIMEOUT(Timeout),
    .CNT_W  (CntW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ifu_req_o      (ifu_req),
    .ifu_req_ready_i(ifu_req_ready),
    .ifu_rvalid_i   (ifu_rvalid),
    .inst_valid_o   (inst_valid),
    .is_load_i      (is_load),
    .is_store_i     (is_store),
    .ebreak_i       (ebreak),
    .exu_rf_wen_i   (exu_rf_wen),
    .lsu_req_o      (lsu_req),
    .lsu_ready_i    (lsu_ready),
    .lsu_done_i     (lsu_done),
    .rf_wen_o       (rf_wen),
    .pc_wen_o       (pc_wen),
    .trap_o         (trap),
    .halted_o       (halted),
    .err_o          (err)
`ifdef EXU_SEQ_CTRL_PERF_EN
    ,
    .cycle_cnt_o    (cycle_cnt),
    .instret_cnt_o  (instret_cnt)
`endif
  );

  typedef struct {
    logic [8:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic [8:0] in, input logic [7:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [8:0] in);
    {rst, ifu_req_ready, ifu_rvalid, is_load, is_store, ebreak, exu_rf_wen, lsu_ready,
     lsu_done} = in;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [8:0] in);
    @(negedge clk);
    drive(in);
    #1;
  endtask

  initial begin
    drive(R);

    // ALU op, 2-cycle fetch latency
    add(R, 8'h00);
    add(RDY, O_REQ);
    add(9'h000, 8'h00);
    add(RV, 8'h00);
    add(WEN, O_IV);
    add(WEN, O_RF | O_PC);
    add(9'h000, O_REQ);
    // store: lsu_ready after 3 cycles, lsu_done 2 cycles after accept
    add(RDY, O_REQ);
    add(RV, 8'h00);
    add(ST | WEN, O_IV);
    add(ST | WEN, O_LSU);
    add(ST | WEN, O_LSU);
    add(ST | WEN | LR, O_LSU);
    add(ST | WEN, 8'h00);
    add(ST | WEN | DN, 8'h00);
    add(ST | WEN, O_PC);
    // stray responses in FETCH are ignored
    add(RV | DN, O_REQ);
    // load with register write
    add(RDY, O_REQ);
    add(RV, 8'h00);
    add(LD | WEN, O_IV);
    add(LD | WEN | LR, O_LSU);
    add(LD | WEN | DN, 8'h00);
    add(LD | WEN, O_RF | O_PC);
    // ebreak beats is_load, then HALT ignores everything
    add(RDY, O_REQ);
    add(RV, 8'h00);
    add(EB | LD, O_IV | O_TRAP);
    add(RDY | RV | LR | DN | WEN, O_HALT);
    add(RV, O_HALT);
    add(R, 8'h00);
    // fetch watchdog expiry after 4 F_WAIT cycles
    add(RDY, O_REQ);
    for (int i = 0; i < 4; i++) add(9'h000, 8'h00);
    add(9'h000, O_ERR);
    add(RDY | RV, O_ERR);
    add(R, 8'h00);
    // rvalid on the 4th F_WAIT cycle wins over expiry
    add(RDY, O_REQ);
    for (int i = 0; i < 3; i++) add(9'h000, 8'h00);
    add(RV, 8'h00);
    add(9'h000, O_IV);
    add(9'h000, O_PC);
    add(9'h000, O_REQ);
    // reset during M_WAIT
    add(RDY, O_REQ);
    add(RV, 8'h00);
    add(LD, O_IV);
    add(LD | LR, O_LSU);
    add(9'h000, 8'h00);
    add(R | DN, 8'h00);
    add(9'h000, O_REQ);
    // reset during MEM masks lsu_req
    add(RDY, O_REQ);
    add(RV, 8'h00);
    add(ST, O_IV);
    add(R | ST, 8'h00);
    // memory watchdog expiry
    add(RDY, O_REQ);
    add(RV, 8'h00);
    add(ST, O_IV);
    add(LR, O_LSU);
    for (int i = 0; i < 4; i++) add(9'h000, 8'h00);
    add(9'h000, O_ERR);
    add(R, 8'h00);
    add(9'h000, O_REQ);
    // lsu_done on the 4th M_WAIT cycle wins over expiry
    add(RDY, O_REQ);
    add(RV, 8'h00);
    add(LD | WEN, O_IV);
    add(LD | WEN | LR, O_LSU);
    for (int i = 0; i < 3; i++) add(9'h000, 8'h00);
    add(DN, 8'h00);
    add(WEN, O_RF | O_PC);
    add(9'h000, O_REQ);

    foreach (vecs[i]) begin
      cyc(vecs[i].in);
      check($sformatf("vec[%0d]", i),
            32'({ifu_req, inst_valid, lsu_req, rf_wen, pc_wen, trap, halted, err}),
            32'(vecs[i].exp));
    end

    // Three back-to-back ALU instructions from a fresh reset
    cyc(R);
    for (int k = 0; k < 3; k++) begin
      cyc(RDY);
      check($sformatf("alu%0d ifu_req", k), 32'(ifu_req), 32'd1);
      cyc(9'h000);
      cyc(RV);
      cyc(WEN);
      check($sformatf("alu%0d inst_valid", k), 32'({inst_valid, rf_wen, pc_wen}), 32'b100);
      cyc(WEN);
      check($sformatf("alu%0d commit", k), 32'({rf_wen, pc_wen}), 32'b11);
    end
    cyc(9'h000);
    check("alu next fetch", 32'(ifu_req), 32'd1);
`ifdef EXU_SEQ_CTRL_PERF_EN
    check("instret_cnt", instret_cnt, 32'd3);
    check("cycle_cnt", cycle_cnt, 32'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exu_seq_ctrl.md
Name: exu_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC execute datapath. Drives the instruction fetch handshake, then the EXU evaluation cycle, an optional load/store memory phase, and the writeback commit. It gates the EXU's register-file write enable and PC update so that each instruction commits exactly once. It also traps on ebreak and flags stalled memory responses with a watchdog.

Parameters:
TIMEOUT, 255, max cycles waited for ifu_rvalid or lsu_done before entering ERR (8-bit watchdog counter)
CNT_W, 32, width of perf counters (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_req  out  1  fetch request, level
ifu_req_ready  in  1  fetch unit accepts request
ifu_rvalid  in  1  instruction word valid (one-cycle pulse)
inst_valid  out  1  one-cycle pulse: IR latched, decode/EXU inputs valid next cycle
is_load  in  1  decoded instruction is a load
is_store  in  1  decoded instruction is a store
ebreak  in  1  decoded instruction is ebreak
exu_rf_wen  in  1  EXU's raw register-write request
lsu_req  out  1  memory request, level
lsu_ready  in  1  LSU accepts request
lsu_done  in  1  memory op complete (one-cycle pulse)
rf_wen  out  1  gated register-file write enable
pc_wen  out  1  PC register loads pc_next
trap  out  1  one-cycle pulse on ebreak (drives npc_trap DPI)
halted  out  1  sticky, set after ebreak
err  out  1  sticky, set on watchdog expiry

Behaviour:
- States: FETCH, F_WAIT, EXEC, MEM, M_WAIT, WB, HALT, ERR. Encoding is free. State is registered; outputs are Moore-decoded from state, except rf_wen.
- Reset (rst=1 at posedge): state=FETCH, watchdog=0. In the reset cycle all outputs are 0. ifu_req rises the cycle after rst deasserts.
- Reset takes effect from any state, including mid-wait, HALT and ERR. It clears halted and err.
- FETCH: ifu_req=1. When ifu_req && ifu_req_ready → F_WAIT. Otherwise hold.
- F_WAIT: watchdog counts up each cycle. On ifu_rvalid → EXEC, inst_valid=1 during the transition cycle (registered pulse), watchdog cleared.
- EXEC: exactly one cycle.
  - If ebreak: go to HALT, trap=1 in that cycle.
  - Else if is_load or is_store: go to MEM.
  - Else: go to WB.
  - If ebreak is set together with is_load or is_store, ebreak has priority.
- MEM: lsu_req=1. When lsu_ready → M_WAIT.
- M_WAIT: watchdog counts. On lsu_done → WB, watchdog cleared.
- WB: exactly one cycle.
  - pc_wen=1.
  - rf_wen = exu_rf_wen && !is_store (combinational).
  - Next state FETCH.
- rf_wen and pc_wen are 0 in every other state. Each instruction yields exactly one pc_wen pulse.
- HALT: all request/enable outputs 0, halted=1. Stays in HALT until reset.
- Watchdog:
  - On the cycle the count reaches TIMEOUT with no response, go to ERR.
  - If the response arrives in that same cycle, the response wins and the normal transition is taken.
  - ERR: outputs 0, err=1. Stays in ERR until reset.
- ifu_rvalid or lsu_done arriving in any state other than its wait state is ignored.
- Handshake rule: a request stays asserted until accepted. A request is never retracted.

Optional Feature:
- Macro: EXU_SEQ_CTRL_PERF_EN.
- When defined, adds outputs cycle_cnt [CNT_W-1:0] and instret_cnt [CNT_W-1:0].
  - cycle_cnt increments every cycle out of reset except in HALT and ERR.
  - instret_cnt increments on each WB cycle.
  - Both are cleared by rst and wrap modulo 2^CNT_W.
- When not defined, neither port nor the counter logic exists.

Test Plan:
- ALU op (addi): ready=1, rvalid 2 cycles after request, exu_rf_wen=1 → FETCH,F_WAIT,F_WAIT,EXEC,WB. Exactly one rf_wen=1 and one pc_wen=1 in WB. Next ifu_req asserted the following cycle.
- Store with lsu_ready delayed 3 cycles and lsu_done 2 cycles after accept, exu_rf_wen=1 → lsu_req held high 3 cycles, rf_wen=0 in WB, pc_wen=1.
- ebreak with is_load=1 → trap pulses 1 cycle in EXEC, state HALT, halted=1. No lsu_req, no pc_wen. Later ifu_rvalid pulses are ignored.
- TIMEOUT=4, ifu_rvalid never arrives → err=1 after 4 F_WAIT cycles. Repeat with rvalid on the 4th cycle → EXEC taken, err=0.
- rst asserted for 1 cycle during M_WAIT → next cycle state FETCH, all outputs 0 in the reset cycle, watchdog=0, halted/err cleared.
- PERF_EN defined, 3 back-to-back ALU instructions, 2-cycle fetch latency → instret_cnt=3 after third WB. cycle_cnt equals elapsed cycles since reset release.
